// File: rtl/des_pkg.sv
// Shared DES ingress types and key-preparation helpers: the PC-1 permutation
// and the odd byte parity check.
package des_pkg;

  localparam int unsigned KEY_RAW_W = 64;
  localparam int unsigned KEY_W     = 56;
  localparam int unsigned BLK_W     = 64;

  // Queued block payload; the sequence tag travels beside it at the top's TAG_W
  typedef struct packed {
    logic [BLK_W-1:0] blk;
    logic [KEY_W-1:0] key;
    logic             decrypt;
  } entry_t;

  // PC-1 source positions, DES numbering (1 = MSB of the raw key)
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  function automatic logic [KEY_W-1:0] pc1(input logic [KEY_RAW_W-1:0] k);
    logic [KEY_W-1:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
    end
    return r;
  endfunction

  function automatic logic odd_parity_ok(input logic [KEY_RAW_W-1:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      ok = ok & (^k[6'(8 * b) +: 8]);
    end
    return ok;
  endfunction

endpackage

// File: rtl/des_ingress_fifo.sv
// Generic registered FIFO with valid/ready on both sides and an occupancy count.
// Pointers reset, storage does not; the head output reads zero while empty.
module des_ingress_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_c, pop_c;

  assign in_ready  = (level_q != LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;

  assign push_c = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_c) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/des_ingress.sv
// DES ingress stage: installs parity-checked PC-1 keys and queues blocks, each
// carrying a snapshot of the key, mode and sequence tag at acceptance time.
module des_ingress
  import des_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter bit          CHECK_PARITY = 1'b1,
  parameter int unsigned TAG_W        = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_load,
  input  logic [63:0]            key,
  output logic                   key_ok,
  output logic                   key_err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_data,
  input  logic                   in_decrypt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_data,
  output logic [55:0]            out_key,
  output logic                   out_decrypt,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned ENT_W = $bits(entry_t) + TAG_W;

  logic [KEY_W-1:0] key_q, key_d;
  logic             key_ok_q, key_ok_d;
  logic             key_err_q, key_err_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             key_good_c;
  logic             fifo_in_valid, fifo_in_ready, push_c;
  entry_t           push_ent, head_ent;
  logic [ENT_W-1:0] push_word, head_word;

  assign key_good_c    = (CHECK_PARITY == 1'b0) || odd_parity_ok(key);
  assign in_ready      = key_ok_q & fifo_in_ready;
  assign fifo_in_valid = in_valid & key_ok_q;
  assign push_c        = in_valid & in_ready;
  assign key_ok        = key_ok_q;
  assign key_err       = key_err_q;

  // Snapshot uses the pre-update key so a same-cycle load affects later blocks only
  always_comb begin
    push_ent         = '0;
    push_ent.blk     = in_data;
    push_ent.key     = key_q;
    push_ent.decrypt = in_decrypt;
  end
  assign push_word = {push_ent, tag_q};

  assign {head_ent, out_tag} = head_word;
  assign out_data    = head_ent.blk;
  assign out_key     = head_ent.key;
  assign out_decrypt = head_ent.decrypt;

  always_comb begin
    key_d     = key_q;
    key_ok_d  = key_ok_q;
    key_err_d = key_err_q;
    tag_d     = tag_q;
    if (key_load) begin
      if (key_good_c) begin
        key_d     = pc1(key);
        key_ok_d  = 1'b1;
        key_err_d = 1'b0;
      end else begin
        key_err_d = 1'b1;
      end
    end
    if (push_c) tag_d = tag_q + TAG_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q     <= '0;
      key_ok_q  <= 1'b0;
      key_err_q <= 1'b0;
      tag_q     <= '0;
    end else begin
      key_q     <= key_d;
      key_ok_q  <= key_ok_d;
      key_err_q <= key_err_d;
      tag_q     <= tag_d;
    end
  end

  des_ingress_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fifo_in_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (push_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_word),
    .level     (level)
  );

endmodule

// File: tb/tb_des_ingress.sv
// Bench for des_ingress: directed steps plus random traffic, checked every
// cycle against a queue-based reference model.
module tb_des_ingress;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;
  localparam logic [63:0] KEY1  = 64'h133457799BBCDFF1;
  localparam logic [55:0] CD1   = 56'hF0CCAAF556678F;

  logic        clk, rst;
  logic        key_load, in_valid, in_decrypt, out_ready;
  logic [63:0] key, in_data;
  logic        key_ok, key_err, in_ready, out_valid, out_decrypt;
  logic [63:0] out_data;
  logic [55:0] out_key;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]  level;

  logic        np_key_load, np_in_valid, np_in_decrypt, np_out_ready;
  logic [63:0] np_key, np_in_data;
  logic        np_key_ok, np_key_err, np_in_ready, np_out_valid, np_out_decrypt;
  logic [63:0] np_out_data;
  logic [55:0] np_out_key;
  logic [TAG_W-1:0] np_out_tag;
  logic [2:0]  np_level;

  des_ingress #(.DEPTH(DEPTH), .CHECK_PARITY(1'b1), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key(key), .key_ok(key_ok),
    .key_err(key_err), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_decrypt(in_decrypt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_key(out_key), .out_decrypt(out_decrypt),
    .out_tag(out_tag), .level(level)
  );

  des_ingress #(.DEPTH(DEPTH), .CHECK_PARITY(1'b0), .TAG_W(TAG_W)) dut_np (
    .clk(clk), .rst(rst), .key_load(np_key_load), .key(np_key), .key_ok(np_key_ok),
    .key_err(np_key_err), .in_valid(np_in_valid), .in_ready(np_in_ready),
    .in_data(np_in_data), .in_decrypt(np_in_decrypt), .out_valid(np_out_valid),
    .out_ready(np_out_ready), .out_data(np_out_data), .out_key(np_out_key),
    .out_decrypt(np_out_decrypt), .out_tag(np_out_tag), .level(np_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [63:0]      data;
    logic [55:0]      key;
    logic             dec;
    logic [TAG_W-1:0] tag;
  } mblk_t;

  mblk_t       mq[$];
  logic [55:0] m_key;
  bit          m_ok, m_err;
  logic [TAG_W-1:0] m_tag;
  int          checks, errors;

  int ref_tab [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                       10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29, 21,13,5,28,20,12,4};

  // Output bit stream in DES order: shift each selected raw bit in from the right
  function automatic logic [55:0] ref_pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    foreach (ref_tab[i]) r = {r[54:0], k[6'(64 - ref_tab[i])]};
    return r;
  endfunction

  function automatic bit ref_parity(input logic [63:0] k);
    logic [7:0] by;
    for (int b = 0; b < 8; b++) begin
      by = 8'(k >> (8 * b));
      if (($countones(by) % 2) == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [63:0] rand_good_key();
    logic [63:0] k;
    logic [7:0]  by;
    k = '0;
    for (int b = 0; b < 8; b++) begin
      by = 8'($urandom);
      if (($countones(by) % 2) == 0) by[0] = ~by[0];
      k = {k[55:0], by};
    end
    return k;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("level",     64'(level),     64'(mq.size()));
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("in_ready",  64'(in_ready),  64'(m_ok && (mq.size() < DEPTH)));
    check("key_ok",    64'(key_ok),    64'(m_ok));
    check("key_err",   64'(key_err),   64'(m_err));
    if (mq.size() != 0) begin
      check("out_data",    out_data,          mq[0].data);
      check("out_key",     64'(out_key),      64'(mq[0].key));
      check("out_decrypt", 64'(out_decrypt),  64'(mq[0].dec));
      check("out_tag",     64'(out_tag),      64'(mq[0].tag));
    end else begin
      check("idle_data", out_data, 64'(0));
      check("idle_key",  64'(out_key), 64'(0));
      check("idle_tag",  64'(out_tag), 64'(0));
    end
  endtask

  // One clock: model decides from pre-edge state, updates at the edge, then compare
  task automatic step();
    bit    acc, pop;
    mblk_t e;
    acc = in_valid && m_ok && (mq.size() < DEPTH);
    pop = (mq.size() != 0) && out_ready;
    e.data = in_data; e.key = m_key; e.dec = in_decrypt; e.tag = m_tag;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_key = '0; m_ok = 1'b0; m_err = 1'b0; m_tag = '0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(e);
        m_tag = m_tag + TAG_W'(1);
      end
      if (key_load) begin
        if (ref_parity(key)) begin
          m_key = ref_pc1(key); m_ok = 1'b1; m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    logic [63:0] nk, rk;
    checks = 0; errors = 0;
    m_key = '0; m_ok = 1'b0; m_err = 1'b0; m_tag = '0;
    rst = 1'b1; key_load = 1'b0; key = '0; in_valid = 1'b0; in_data = '0;
    in_decrypt = 1'b0; out_ready = 1'b0;
    np_key_load = 1'b0; np_key = '0; np_in_valid = 1'b0; np_in_data = '0;
    np_in_decrypt = 1'b0; np_out_ready = 1'b1;
    @(negedge clk);
    step(); step();
    rst = 1'b0;

    // No key installed: offers are refused
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0001;
    step();
    check("nokey_in_ready", 64'(in_ready), 64'(0));
    check("nokey_out_valid", 64'(out_valid), 64'(0));

    // Known-answer key and first block
    in_valid = 1'b0; key = KEY1; key_load = 1'b1;
    step();
    key_load = 1'b0;
    check("kat_key_ok", 64'(key_ok), 64'(1));
    in_data = 64'h0123456789ABCDEF; in_decrypt = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("kat_out_key", 64'(out_key), 64'(CD1));
    check("kat_out_data", out_data, 64'h0123456789ABCDEF);
    check("kat_out_tag", 64'(out_tag), 64'(0));
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Bad parity: rejected here, installed on the no-check instance
    key = KEY1 ^ 64'h1; key_load = 1'b1; np_key = KEY1 ^ 64'h1; np_key_load = 1'b1;
    step();
    key_load = 1'b0; np_key_load = 1'b0;
    check("bad_key_err", 64'(key_err), 64'(1));
    check("bad_key_ok", 64'(key_ok), 64'(1));
    check("np_key_ok", 64'(np_key_ok), 64'(1));
    check("np_key_err", 64'(np_key_err), 64'(0));
    in_data = {$urandom, $urandom}; in_valid = 1'b1;
    np_in_data = 64'h1111_2222_3333_4444; np_in_valid = 1'b1;
    step();
    in_valid = 1'b0; np_in_valid = 1'b0;
    check("bad_keeps_key", 64'(out_key), 64'(CD1));
    check("np_out_key", 64'(np_out_key), 64'(ref_pc1(KEY1 ^ 64'h1)));
    check("np_out_data", np_out_data, 64'h1111_2222_3333_4444);
    rk = rand_good_key() ^ (64'h1 << (8 * $urandom_range(0, 7)));
    np_key = rk; np_key_load = 1'b1;
    step();
    np_key_load = 1'b0; np_in_valid = 1'b1; np_in_data = {$urandom, $urandom};
    step();
    np_in_valid = 1'b0;
    check("np_rand_key", 64'(np_out_key), 64'(ref_pc1(rk)));
    check("np_rand_err", 64'(np_key_err), 64'(0));
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Fill past capacity with downstream stalled, then release
    for (int i = 0; i < 5; i++) begin
      in_data = {$urandom, $urandom}; in_decrypt = 1'($urandom); in_valid = 1'b1;
      step();
    end
    check("full_level", 64'(level), 64'(4));
    check("full_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    step(); step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b0;

    // Key load in the same cycle as a push
    nk = rand_good_key();
    key = nk; key_load = 1'b1; in_valid = 1'b1; in_data = {$urandom, $urandom};
    step();
    key_load = 1'b0; in_data = {$urandom, $urandom};
    step();
    in_valid = 1'b0;
    check("same_cycle_old_key", 64'(out_key), 64'(CD1));
    out_ready = 1'b1;
    step();
    check("next_block_new_key", 64'(out_key), 64'(ref_pc1(nk)));
    step(); step();
    out_ready = 1'b0;

    // Reset mid-stream with blocks queued and one offered
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom}; step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_level", 64'(level), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_key_ok", 64'(key_ok), 64'(0));
    step();

    // Tag wrap across 2^TAG_W+1 blocks with free-flowing output
    key = KEY1; key_load = 1'b1; step(); key_load = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom}; in_decrypt = 1'($urandom);
      step();
      if (i == 15) check("tag_15", 64'(out_tag), 64'(15));
      if (i == 16) check("tag_wrap", 64'(out_tag), 64'(0));
    end
    in_valid = 1'b0;
    step();

    // Random traffic with occasional good and bad key loads
    for (int i = 0; i < 300; i++) begin
      in_valid   = ($urandom % 4) != 0;
      out_ready  = ($urandom % 3) != 0;
      in_data    = {$urandom, $urandom};
      in_decrypt = 1'($urandom);
      key_load   = ($urandom % 12) == 0;
      key        = (($urandom % 2) == 0) ? rand_good_key() : {$urandom, $urandom};
      step();
    end
    key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
